// File: rtl/imm_pkg.sv
// Shared immediate-extension mode encodings and a width-generic reference extender.
package imm_pkg;

    localparam int unsigned IMM_MODE_W = 3;

    typedef enum logic [2:0] {
        IMM_SEXT  = 3'd0,
        IMM_ZEXT  = 3'd1,
        IMM_LUI   = 3'd2,
        IMM_BROFF = 3'd3
    } imm_mode_t;

    // Widths are runtime arguments so one function serves every IMM_W/DATA_W pairing;
    // the result is right-aligned in 64 bits and masked to data_w.
    function automatic logic [63:0] imm_extend(input logic [63:0] imm,
                                               input logic [IMM_MODE_W-1:0] mode,
                                               input int unsigned imm_w,
                                               input int unsigned data_w);
        logic [63:0] mask_d;
        logic [63:0] mask_i;
        logic [63:0] zext;
        logic [63:0] sext;
        logic [63:0] res;
        mask_d = (64'd1 << data_w) - 64'd1;
        mask_i = (64'd1 << imm_w) - 64'd1;
        zext   = imm & mask_i;
        sext   = imm[imm_w-1] ? (zext | ~mask_i) : zext;
        case (mode)
            IMM_SEXT:  res = sext;
            IMM_ZEXT:  res = zext;
            IMM_LUI:   res = zext << (data_w - imm_w);
            IMM_BROFF: res = sext << 2;
            default:   res = 64'd0;
        endcase
        return res & mask_d;
    endfunction

endpackage

// File: rtl/imm_extend_core.sv
// Combinational immediate extension mux; flags mode codes outside the defined set.
module imm_extend_core
    import imm_pkg::*;
#(
    parameter int unsigned IMM_W  = 16,
    parameter int unsigned DATA_W = 32
) (
    input  logic [IMM_W-1:0]      imm,
    input  logic [IMM_MODE_W-1:0] mode,
    output logic [DATA_W-1:0]     data,
    output logic                  err
);

    logic [DATA_W-1:0] zext;
    logic [DATA_W-1:0] sext;

    assign zext = {{(DATA_W-IMM_W){1'b0}}, imm};
    assign sext = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};

    always_comb begin
        data = '0;
        err  = 1'b0;
        case (mode)
            IMM_SEXT:  data = sext;
            IMM_ZEXT:  data = zext;
            IMM_LUI:   data = {imm, {(DATA_W-IMM_W){1'b0}}};
            IMM_BROFF: data = {sext[DATA_W-3:0], 2'b00};
            default:   err  = 1'b1;
        endcase
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// Registered immediate extender with a two-entry (main + skid) buffer on a valid/ready handshake.
module imm_extend_pipe
    import imm_pkg::*;
#(
    parameter int unsigned IMM_W  = 16,
    parameter int unsigned DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [IMM_W-1:0]      in_imm,
    input  logic [IMM_MODE_W-1:0] in_mode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_data,
    output logic                  out_err
);

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] TWO   = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic              main_err_q, main_err_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic              skid_err_q, skid_err_d;

    logic [DATA_W-1:0] ext_data;
    logic              ext_err;
    logic              in_xfer;
    logic              out_xfer;

    imm_extend_core #(
        .IMM_W (IMM_W),
        .DATA_W(DATA_W)
    ) u_core (
        .imm (in_imm),
        .mode(in_mode),
        .data(ext_data),
        .err (ext_err)
    );

    // Both handshake outputs come straight from state, so neither sees out_ready combinationally.
    assign out_valid = (state_q != EMPTY);
    assign in_ready  = (state_q != TWO);
    assign out_data  = main_data_q;
    assign out_err   = main_err_q;

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_err_d  = main_err_q;
        skid_data_d = skid_data_q;
        skid_err_d  = skid_err_q;
        case (state_q)
            EMPTY: begin
                if (in_xfer) begin
                    main_data_d = ext_data;
                    main_err_d  = ext_err;
                    state_d     = ONE;
                end
            end
            ONE: begin
                if (in_xfer && out_xfer) begin
                    main_data_d = ext_data;
                    main_err_d  = ext_err;
                end else if (in_xfer) begin
                    skid_data_d = ext_data;
                    skid_err_d  = ext_err;
                    state_d     = TWO;
                end else if (out_xfer) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (out_xfer) begin
                    main_data_d = skid_data_q;
                    main_err_d  = skid_err_q;
                    state_d     = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= EMPTY;
            main_data_q <= '0;
            main_err_q  <= 1'b0;
            skid_data_q <= '0;
            skid_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_err_q  <= main_err_d;
            skid_data_q <= skid_data_d;
            skid_err_q  <= skid_err_d;
        end
    end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed bench: modes, illegal codes, backpressure, throughput, async reset, narrow widths.
module tb_imm_extend_pipe;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_imm;
    logic [2:0]  in_mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_err;

    logic        in_valid8;
    logic        in_ready8;
    logic [7:0]  in_imm8;
    logic [2:0]  in_mode8;
    logic        out_valid8;
    logic        out_ready8;
    logic [15:0] out_data8;
    logic        out_err8;

    int passed = 0;
    int total  = 0;

    imm_extend_pipe #(
        .IMM_W (16),
        .DATA_W(32)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_imm   (in_imm),
        .in_mode  (in_mode),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_err  (out_err)
    );

    imm_extend_pipe #(
        .IMM_W (8),
        .DATA_W(16)
    ) dut8 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid8),
        .in_ready (in_ready8),
        .in_imm   (in_imm8),
        .in_mode  (in_mode8),
        .out_valid(out_valid8),
        .out_ready(out_ready8),
        .out_data (out_data8),
        .out_err  (out_err8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Advance past the next rising edge; checks then see the post-edge state.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_imm     = 16'h0;
        in_mode    = 3'd0;
        out_ready  = 1'b1;
        in_valid8  = 1'b0;
        in_imm8    = 8'h0;
        in_mode8   = 3'd0;
        out_ready8 = 1'b1;

        // Reset state, with a beat offered that must be discarded
        in_valid = 1'b1;
        in_imm   = 16'h5555;
        tick();
        tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_data", out_data, 32'h0);
        check("rst_out_err", 32'(out_err), 32'd0);
        in_valid = 1'b0;
        #2 rst = 1'b0;
        tick();
        check("post_rst_empty", 32'(out_valid), 32'd0);

        // Basic modes, imm=0x8004
        in_valid = 1'b1;
        in_imm   = 16'h8004;
        in_mode  = 3'd0;
        tick();
        check("sext_valid", 32'(out_valid), 32'd1);
        check("sext_data", out_data, 32'hFFFF8004);
        check("sext_err", 32'(out_err), 32'd0);
        in_mode = 3'd1;
        tick();
        check("zext_data", out_data, 32'h00008004);
        check("zext_err", 32'(out_err), 32'd0);
        in_mode = 3'd2;
        tick();
        check("lui_data", out_data, 32'h80040000);
        check("lui_err", 32'(out_err), 32'd0);
        in_mode = 3'd3;
        tick();
        check("broff_data", out_data, 32'hFFFE0010);
        check("broff_err", 32'(out_err), 32'd0);

        // Illegal mode, then a legal beat clears the error
        in_mode = 3'd5;
        in_imm  = 16'h1234;
        tick();
        check("illegal_data", out_data, 32'h0);
        check("illegal_err", 32'(out_err), 32'd1);
        in_mode = 3'd0;
        in_imm  = 16'h0001;
        tick();
        check("legal_after_data", out_data, 32'h00000001);
        check("legal_after_err", 32'(out_err), 32'd0);
        in_valid = 1'b0;
        tick();
        check("drain_empty", 32'(out_valid), 32'd0);

        // Backpressure: beats 1..6 (ZEXT), out_ready low across 3 edges
        in_mode  = 3'd1;
        in_valid = 1'b1;
        in_imm   = 16'd1;
        tick();
        check("bp_b1_data", out_data, 32'd1);
        check("bp_b1_in_ready", 32'(in_ready), 32'd1);
        in_imm    = 16'd2;
        out_ready = 1'b0;
        tick();
        check("bp_two_in_ready", 32'(in_ready), 32'd0);
        check("bp_stall1_data", out_data, 32'd1);
        check("bp_stall1_valid", 32'(out_valid), 32'd1);
        in_imm = 16'd3;
        tick();
        check("bp_stall2_data", out_data, 32'd1);
        check("bp_stall2_in_ready", 32'(in_ready), 32'd0);
        tick();
        check("bp_stall3_data", out_data, 32'd1);
        check("bp_stall3_in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        tick();
        check("bp_b2_data", out_data, 32'd2);
        check("bp_b2_in_ready", 32'(in_ready), 32'd1);
        tick();
        check("bp_b3_data", out_data, 32'd3);
        in_imm = 16'd4;
        tick();
        check("bp_b4_data", out_data, 32'd4);
        in_imm = 16'd5;
        tick();
        check("bp_b5_data", out_data, 32'd5);
        in_imm = 16'd6;
        tick();
        check("bp_b6_data", out_data, 32'd6);
        in_valid = 1'b0;
        tick();
        check("bp_drain_empty", 32'(out_valid), 32'd0);

        // Full throughput: 20 back-to-back beats
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_imm = 16'(16'h0100 + i);
            tick();
            check("tp_valid", 32'(out_valid), 32'd1);
            check("tp_data", out_data, 32'(32'h0100 + i));
        end
        in_valid = 1'b0;
        tick();
        check("tp_drain_empty", 32'(out_valid), 32'd0);

        // Reset mid-operation from TWO
        in_valid  = 1'b1;
        out_ready = 1'b0;
        in_imm    = 16'h000A;
        tick();
        in_imm = 16'h000B;
        tick();
        check("mid_two_in_ready", 32'(in_ready), 32'd0);
        #2 rst = 1'b1;
        #1;
        check("async_out_valid", 32'(out_valid), 32'd0);
        check("async_in_ready", 32'(in_ready), 32'd1);
        check("async_out_data", out_data, 32'h0);
        tick();
        check("held_rst_out_valid", 32'(out_valid), 32'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #3 rst = 1'b0;
        tick();
        check("no_stale_1", 32'(out_valid), 32'd0);
        tick();
        check("no_stale_2", 32'(out_valid), 32'd0);

        // Narrow instance: IMM_W=8, DATA_W=16, imm=0x80
        in_valid8 = 1'b1;
        in_imm8   = 8'h80;
        in_mode8  = 3'd0;
        tick();
        check("w8_sext", {16'h0, out_data8}, 32'h0000FF80);
        in_mode8 = 3'd2;
        tick();
        check("w8_lui", {16'h0, out_data8}, 32'h00008000);
        in_mode8 = 3'd3;
        tick();
        check("w8_broff", {16'h0, out_data8}, 32'h0000FE00);
        check("w8_err", 32'(out_err8), 32'd0);
        in_mode8 = 3'd7;
        tick();
        check("w8_illegal_err", 32'(out_err8), 32'd1);
        check("w8_illegal_data", {16'h0, out_data8}, 32'h0);
        in_valid8 = 1'b0;
        tick();
        check("w8_drain_empty", 32'(out_valid8), 32'd0);
        check("w8_in_ready", 32'(in_ready8), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/imm_extend_pipe.md
# imm_extend_pipe

Parametrised, registered immediate-extension stage for the MIPS datapath, succeeding the fixed 16-to-32 combinational sign extender. It accepts an immediate field plus an extension mode over a valid/ready handshake. It produces the DATA_W-bit extended value one cycle later and has a two-entry skid buffer, so it can sit between the decode and execute stages of the pipelined core without breaking the ready path. Mode encodings are shared with the control unit through a package.

## Interface
- IMM_W, 16, width of the incoming immediate field; legal range 4..DATA_W-2
- DATA_W, 32, width of the extended result
- clk  input  1  rising-edge clock; the only clock
- rst  input  1  reset, asynchronous and active-high
- in_valid  input  1  upstream beat present
- in_ready  output  1  block can accept a beat this cycle
- in_imm  input  IMM_W  raw immediate field (instr[IMM_W-1:0])
- in_mode  input  3  extension mode, imm_mode_t encoding
- out_valid  output  1  result beat present
- out_ready  input  1  downstream accepts the beat this cycle
- out_data  output  DATA_W  extended immediate
- out_err  output  1  beat carried an illegal mode code

## Operation
- Modes, with all arithmetic in DATA_W bits:
  - SEXT=0: {(DATA_W-IMM_W){imm[MSB]}, imm}
  - ZEXT=1: zero-extended imm
  - LUI=2: imm placed at bits [DATA_W-1:DATA_W-IMM_W]; lower bits 0
  - BROFF=3: SEXT result shifted left by 2; bits shifted out are discarded
  - codes 4..7: out_data=0, out_err=1
- Extension is combinational on the input side. The result is captured into the output register, or into the skid register when the output is stalled.
- Storage is an output register (main) plus one skid register. Occupancy is 0, 1 or 2 beats.
- in_ready = NOT skid_valid. This is registered, with no combinational path from out_ready.
- Input transfer: in_valid AND in_ready. Output transfer: out_valid AND out_ready.
- State (occupancy) transitions:
  - EMPTY: input transfer → ONE.
  - ONE:
    - input and output transfers together → ONE (new beat loads main)
    - input transfer only → TWO (new beat loads skid)
    - output transfer only → EMPTY
  - TWO: output transfer → ONE (skid moves to main). No input is accepted in TWO.
- Ordering is strictly FIFO. A beat is never dropped or duplicated.
- out_data and out_err hold stable while out_valid=1 and out_ready=0.

## Timing
- Latency: 1 cycle. A beat accepted at edge N is visible with out_valid=1 after edge N.
- Throughput: 1 beat/cycle while out_ready=1.
- Reset values, applied asynchronously:
  - out_valid=0, out_data=0, out_err=0
  - skid empty, so in_ready=1
  - occupancy EMPTY
- Beats presented while rst=1 are discarded.
- Reset mid-operation flushes both entries immediately. No beat survives reset.
- After out_ready drops, in_ready falls one cycle after the beat that fills the skid. The skid absorbs exactly that one in-flight beat.
- Simultaneous input and output transfer in ONE keeps occupancy at ONE, with no bubble.
- out_valid must not depend combinationally on out_ready.

## Structure
- Package imm_pkg holds:
  - typedef enum logic [2:0] imm_mode_t {IMM_SEXT, IMM_ZEXT, IMM_LUI, IMM_BROFF}
  - localparam IMM_MODE_W=3
  - an extend function imm_extend(imm, mode) parametrised via DATA_W/IMM_W arguments, or a macro-free generic function
- Sub-module imm_extend_core holds the pure combinational mode mux, with the same function as the package function. The top instantiates it once, ahead of the skid logic.
- The skid control, the registers and the handshake live in imm_extend_pipe.

## Test plan
- Basic modes (IMM_W=16, DATA_W=32, out_ready=1), imm=0x8004. Expected out_data one cycle later:
  - SEXT → 0xFFFF8004
  - ZEXT → 0x00008004
  - LUI → 0x80040000
  - BROFF → 0xFFFE0010
  - out_err=0 for all four
- Illegal mode: in_mode=5, imm=0x1234 → out_data=0x00000000, out_err=1. The next legal beat has out_err=0.
- Backpressure: stream beats 1..6 with out_ready low for 3 cycles mid-stream.
  - in_ready drops after exactly 2 stored beats.
  - Output order is 1..6 with no loss or duplication.
  - out_data is stable while stalled.
- Full throughput: in_valid=1 and out_ready=1 for 20 cycles with an incrementing imm → 20 results on consecutive cycles after a 1-cycle latency.
- Reset mid-operation: reach TWO, then assert rst asynchronously between edges.
  - out_valid=0 and in_ready=1 take effect immediately.
  - No stale beat appears after release.
- Parameter sweep IMM_W=8, DATA_W=16, imm=0x80:
  - SEXT → 0xFF80
  - LUI → 0x8000
  - BROFF → 0xFE00
